// File: rtl/agc_controller_if.sv
// Stream and control signals between the detector front-end and agc_controller.
// The master side drives samples and enable; the slave side is the controller.
`timescale 1ns/1ps
interface agc_controller_if;
    logic [7:0]        signal_dB_i;
    logic              valid_i;
    logic              enable_i;
    logic [7:0]        signal_dB_o;
    logic              valid_o;
    logic signed [5:0] gain_dB_o;
    logic              gain_update_o;
    logic              settled_o;

    modport master (
        output signal_dB_i, valid_i, enable_i,
        input  signal_dB_o, valid_o, gain_dB_o, gain_update_o, settled_o
    );

    modport slave (
        input  signal_dB_i, valid_i, enable_i,
        output signal_dB_o, valid_o, gain_dB_o, gain_update_o, settled_o
    );
endinterface

// File: rtl/agc_controller.sv
// Windowed-average AGC loop: steps the gain code in 4 dB units toward the
// target band and blanks the forwarded stream while the amplifier settles.
`timescale 1ns/1ps
module agc_controller #(
    parameter int GAIN_MIN      = -4,
    parameter int GAIN_MAX      = 15,
    parameter int GAIN_INIT     = 0,
    parameter int TARGET_HI     = 200,
    parameter int TARGET_LO     = 150,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    agc_controller_if.slave  bus
);
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]        T_HI     = 8'(TARGET_HI);
    localparam logic [7:0]        T_LO     = 8'(TARGET_LO);
    localparam logic signed [7:0] G_MIN    = 8'(GAIN_MIN);
    localparam logic signed [7:0] G_MAX    = 8'(GAIN_MAX);

    typedef enum logic [1:0] {ACQUIRE, DECIDE, SETTLE} state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [7:0]          sig_q, sig_d;
    logic                vld_q, vld_d;
    logic signed [5:0]   gain_q, gain_d;
    logic                upd_q, upd_d;

    logic [7:0]          avg;
    logic signed [7:0]   gain_ext, raw, tgt;
    logic                change;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ACQUIRE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            settle_q <= '0;
            sig_q    <= '0;
            vld_q    <= 1'b0;
            gain_q   <= 6'(GAIN_INIT);
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            settle_q <= settle_d;
            sig_q    <= sig_d;
            vld_q    <= vld_d;
            gain_q   <= gain_d;
            upd_q    <= upd_d;
        end
    end

    // Target is formed and clamped at 8 bits so gain-2 near the 6-bit floor cannot wrap.
    always_comb begin
        avg      = 8'(acc_q >> AVG_LOG2);
        gain_ext = {{2{gain_q[5]}}, gain_q};
        if (sat_q)            raw = gain_ext - 8'sd2;
        else if (avg > T_HI)  raw = gain_ext - 8'sd1;
        else if (avg < T_LO)  raw = gain_ext + 8'sd1;
        else                  raw = gain_ext;
        if (raw < G_MIN)      tgt = G_MIN;
        else if (raw > G_MAX) tgt = G_MAX;
        else                  tgt = raw;
        change = (tgt != gain_ext);
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable_i) begin
            state_d = ACQUIRE;
        end else begin
            case (state_q)
                ACQUIRE: if (bus.valid_i && cnt_q == LAST_CNT) state_d = DECIDE;
                DECIDE:  state_d = change ? SETTLE : ACQUIRE;
                SETTLE:  if (settle_q == '0) state_d = ACQUIRE;
                default: state_d = ACQUIRE;
            endcase
        end
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        settle_d = settle_q;
        sig_d    = sig_q;
        vld_d    = 1'b0;
        gain_d   = gain_q;
        upd_d    = 1'b0;
        if (!bus.enable_i) begin
            // Loop frozen: window state discarded, stream passes straight through.
            acc_d    = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
            settle_d = '0;
            if (bus.valid_i) begin
                sig_d = bus.signal_dB_i;
                vld_d = 1'b1;
            end
        end else begin
            case (state_q)
                ACQUIRE: begin
                    if (bus.valid_i) begin
                        sig_d = bus.signal_dB_i;
                        vld_d = 1'b1;
                        acc_d = acc_q + ACC_W'(bus.signal_dB_i);
                        sat_d = sat_q | (bus.signal_dB_i == 8'hFF);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DECIDE: begin
                    acc_d = '0;
                    cnt_d = '0;
                    sat_d = 1'b0;
                    if (change) begin
                        gain_d   = tgt[5:0];
                        upd_d    = 1'b1;
                        settle_d = SET_W'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (settle_q != '0) settle_d = settle_q - SET_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.signal_dB_o   = sig_q;
    assign bus.valid_o       = vld_q;
    assign bus.gain_dB_o     = gain_q;
    assign bus.gain_update_o = upd_q;
    assign bus.settled_o     = (state_q != SETTLE);
endmodule
